// File: rtl/io_tile_cfg_array.sv
// Multi-channel embedded-IO tile: NUM_IO pads configured through one serial chain.
// A shadow register applies each completed configuration word atomically.
module io_tile_cfg_array #(
  parameter int NUM_IO   = 4,
  parameter int CFG_BITS = 3,
  parameter int CNT_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  output logic              cfg_done,
  input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_DIR,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad
);

  localparam int S = NUM_IO * CFG_BITS;

  typedef enum logic [2:0] {
    UNCFG    = 3'd0,
    SHIFT    = 3'd1,
    LOAD     = 3'd2,
    LOADED   = 3'd3,
    SHIFT_RE = 3'd4
  } state_t;

  state_t           state;
  logic [S-1:0]     chain;
  logic [S-1:0]     shadow;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  assign last_bit  = ccff_en && (cnt == CNT_W'(S - 1));
  assign ccff_tail = chain[S-1];

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state    <= UNCFG;
      chain    <= '0;
      shadow   <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
    end else begin
      if (ccff_en) begin
        chain <= {chain[S-2:0], ccff_head};
        cnt   <= last_bit ? '0 : cnt + 1'b1;
      end
      case (state)
        UNCFG: begin
          if (ccff_en) state <= last_bit ? LOAD : SHIFT;
        end
        SHIFT, SHIFT_RE: begin
          if (last_bit) state <= LOAD;
        end
        LOAD: begin
          // chain still holds the completed word here; a concurrent shift
          // already counted above as bit 1 of the next word.
          shadow   <= chain;
          cfg_done <= 1'b1;
          state    <= ccff_en ? SHIFT_RE : LOADED;
        end
        LOADED: begin
          if (ccff_en) state <= last_bit ? LOAD : SHIFT_RE;
        end
        default: state <= UNCFG;
      endcase
    end
  end

  // Per-channel layout {inv_out, inv_in, dir}; unconfigured pads stay input-safe.
  for (genvar g = 0; g < NUM_IO; g++) begin : g_ch
    logic dir, inv_in, inv_out;
    assign dir     = shadow[g*CFG_BITS];
    assign inv_in  = shadow[g*CFG_BITS + 1];
    assign inv_out = shadow[g*CFG_BITS + 2];

    assign gfpga_pad_EMBEDDED_IO_SOC_DIR[g] = cfg_done & dir;
    assign gfpga_pad_EMBEDDED_IO_SOC_OUT[g] = cfg_done & dir & (io_outpad[g] ^ inv_out);
    assign io_inpad[g] = cfg_done & ~dir & (gfpga_pad_EMBEDDED_IO_SOC_IN[g] ^ inv_in);
  end

endmodule

// File: tb/tb_io_tile_cfg_array.sv
// Bench for io_tile_cfg_array: directed sequences, a datapath vector table and
// randomized traffic against a bit-history reference model.
module tb_io_tile_cfg_array;

  localparam int N  = 4;
  localparam int CB = 3;
  localparam int S  = N * CB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         head = 1'b0;
  logic [N-1:0] soc_in = '0;
  logic [N-1:0] outpad = '0;
  logic         tail, done;
  logic [N-1:0] soc_out, dir, inpad;

  io_tile_cfg_array #(.NUM_IO(N), .CFG_BITS(CB), .CNT_W(8)) dut (
    .prog_clk                      (clk),
    .pReset_n                      (rst_n),
    .ccff_en                       (en),
    .ccff_head                     (head),
    .ccff_tail                     (tail),
    .cfg_done                      (done),
    .gfpga_pad_EMBEDDED_IO_SOC_IN  (soc_in),
    .gfpga_pad_EMBEDDED_IO_SOC_OUT (soc_out),
    .gfpga_pad_EMBEDDED_IO_SOC_DIR (dir),
    .io_outpad                     (outpad),
    .io_inpad                      (inpad)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the most recent S shifted bits, a word-bit count,
  // a pending-load flag and the applied configuration.
  bit           hist[$];
  int           nbits;
  bit           pend;
  bit           m_done;
  logic [S-1:0] m_shadow;

  typedef struct {
    logic [N-1:0] outpad;
    logic [N-1:0] soc_in;
    logic [N-1:0] exp_out;
    logic [N-1:0] exp_in;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    nbits    = 0;
    pend     = 1'b0;
    m_done   = 1'b0;
    m_shadow = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (pend) begin
        for (int j = 0; j < S; j++) m_shadow[j] = hist[S-1-j];
        m_done = 1'b1;
        pend   = 1'b0;
      end
      if (en) begin
        hist.push_back(head);
        if (hist.size() > S) void'(hist.pop_front());
        nbits++;
        if (nbits == S) begin
          nbits = 0;
          pend  = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] e_dir, e_out, e_in;
    logic         e_tail;
    for (int i = 0; i < N; i++) begin
      e_dir[i] = m_done & m_shadow[i*CB];
      e_out[i] = m_done & m_shadow[i*CB] & (outpad[i] ^ m_shadow[i*CB+2]);
      e_in[i]  = m_done & ~m_shadow[i*CB] & (soc_in[i] ^ m_shadow[i*CB+1]);
    end
    e_tail = (hist.size() == S) ? hist[0] : 1'b0;
    chk(tag, {18'd0, tail, done, dir, soc_out, inpad}, {18'd0, e_tail, m_done, e_dir, e_out, e_in});
  endtask

  task automatic step(input bit e, input bit h);
    en   = e;
    head = h;
    @(posedge clk);
    model_edge();
    #1;
    check_all("cycle");
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_now", {20'd0, tail, done, dir, soc_out, inpad}, 32'd0);
    step(1'b1, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic shift_word(input logic [S-1:0] w);
    for (int k = S - 1; k >= 0; k--) step(1'b1, w[k]);
  endtask

  logic [S-1:0] word1, word2;
  bit           pat[40];

  initial begin
    vecs[0] = '{4'b1111, 4'b0000, 4'b0001, 4'b0100};
    vecs[1] = '{4'b0000, 4'b1111, 4'b0010, 4'b1000};
    vecs[2] = '{4'b0101, 4'b1010, 4'b0011, 4'b1100};
    vecs[3] = '{4'b1010, 4'b0101, 4'b0000, 4'b0000};
    word1 = 12'b000_010_101_001;
    word2 = 12'b100_011_110_100;
    model_reset();

    // Reset hold with toggling inputs
    for (int c = 0; c < 4; c++) begin
      outpad = 4'($urandom);
      soc_in = 4'($urandom);
      step(1'b1, c[0]);
      chk("reset_hold", {20'd0, tail, done, dir, soc_out, inpad}, 32'd0);
    end
    rst_n = 1'b1;

    // Full load
    outpad = 4'b1111;
    soc_in = 4'b0000;
    for (int k = S - 1; k >= 0; k--) begin
      step(1'b1, word1[k]);
      chk("done_early", {31'd0, done}, 32'd0);
    end
    step(1'b0, 1'b0);
    chk("done_after_load", {31'd0, done}, 32'd1);
    chk("dir_load", {28'd0, dir}, 32'h3);
    for (int v = 0; v < 4; v++) begin
      outpad = vecs[v].outpad;
      soc_in = vecs[v].soc_in;
      #1;
      chk("vec_out", {28'd0, soc_out}, {28'd0, vecs[v].exp_out});
      chk("vec_in", {28'd0, inpad}, {28'd0, vecs[v].exp_in});
      chk("vec_dir", {28'd0, dir}, 32'h3);
    end

    // Reconfigure while loaded
    outpad = 4'b1111;
    soc_in = 4'b0000;
    for (int k = S - 1; k >= 0; k--) begin
      step(1'b1, word2[k]);
      chk("reconf_old_dir", {27'd0, done, dir}, 32'h13);
    end
    step(1'b0, 1'b0);
    chk("reconf_new_dir", {27'd0, done, dir}, 32'h14);
    chk("reconf_new_out", {28'd0, soc_out}, 32'h4);

    // Async reset mid-shift, then partial shift with a pause
    for (int k = 0; k < 6; k++) step(1'b1, k[0]);
    async_reset();
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0);
      chk("pause_safe", {27'd0, done, dir}, 32'd0);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1);
    chk("partial_11", {31'd0, done}, 32'd0);
    step(1'b1, 1'b1);
    chk("partial_12", {31'd0, done}, 32'd0);
    step(1'b0, 1'b0);
    chk("partial_done", {31'd0, done}, 32'd1);

    // Chain pass-through
    for (int k = 0; k < 40; k++) pat[k] = (k % 4 != 1);
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, pat[k-1]);
      if (k >= S) chk("passthru", {31'd0, tail}, {31'd0, pat[k-S]});
    end

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      outpad = 4'($urandom);
      soc_in = 4'($urandom);
      if ($urandom_range(0, 149) == 0) async_reset();
      else step($urandom_range(0, 9) < 7, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
